// File: rtl/multicycle_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// multicycle_pkg
//
// Shared definitions for the multicycle RV32I-subset control unit:
//   - statetype      : main FSM state encoding (4 bits, exported on state_o)
//   - OP_*           : opcodes of the supported instructions
//   - ALUOP_*        : coarse ALU operation class from the FSM to the decoder
//   - ALU_*          : ALUControl encodings understood by the datapath ALU
//   - RES_*, SRCA_*, SRCB_* : datapath multiplexer select constants
//   - IMM_*          : immediate format selects
//   - funct3Supported: funct3 values the ALU decoder knows for R/I ops
// ---------------------------------------------------------------------------
package multicycle_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10,
        TRAP     = 4'd11
    } statetype;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Only add/sub, slt, or and and are implemented by the ALU.
    function automatic logic funct3Supported(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b010) ||
               (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// ---------------------------------------------------------------------------
// alu_decoder
//
// Combinational translation of the FSM's ALUOp class plus instruction fields
// into the datapath ALUControl code.
//
// Ports:
//   ALUOp      in  2  operation class (add / sub / decode funct3)
//   op5        in  1  opcode bit 5, distinguishes R-type from I-type
//   funct3     in  3  instruction funct3
//   funct7b5   in  1  instruction bit 30
//   ALUControl out 3  ALU operation code
// ---------------------------------------------------------------------------
module alu_decoder
    import multicycle_pkg::*;
(
    input  logic [1:0] ALUOp,
    input  logic       op5,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [2:0] ALUControl
);

    // addi has no funct7 field, so bit 30 only selects sub for R-type.
    always_comb begin
        ALUControl = ALU_ADD;
        case (ALUOp)
            ALUOP_ADD: ALUControl = ALU_ADD;
            ALUOP_SUB: ALUControl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  ALUControl = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  ALUControl = ALU_SLT;
                    3'b110:  ALUControl = ALU_OR;
                    3'b111:  ALUControl = ALU_AND;
                    default: ALUControl = ALU_ADD;
                endcase
            end
            default: ALUControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//
// Main control FSM of the multicycle RV32I-subset core (lw, sw, R, I, beq,
// jal). Drives every select, enable and strobe of the shared datapath.
// Outputs are decoded from the state register (and Zero for PCWrite); the
// write strobes are additionally forced low while reset is asserted.
//
// Parameter:
//   MEM_WAIT   extra wait cycles in FETCH, MEMREAD and MEMWRITE (0..7)
//
// Optional feature macro: MULTICYCLE_CTRL_TRAP_EN
//   When defined, unknown opcodes or unsupported R/I funct3 values enter a
//   sticky TRAP state and the illegal_o port is present. Otherwise unknown
//   instructions are skipped as NOPs.
//
// Ports:
//   clk        in  1  core clock, rising edge
//   reset      in  1  asynchronous active-low reset
//   op         in  7  Instr[6:0]
//   funct3     in  3  Instr[14:12]
//   funct7b5   in  1  Instr[30]
//   Zero       in  1  ALU zero flag
//   PCWrite    out 1  PC enable
//   AdrSrc     out 1  memory address select (0 PC, 1 ALUOut)
//   MemWrite   out 1  memory write strobe
//   IRWrite    out 1  IR/OldPC enable
//   RegWrite   out 1  register-file write enable
//   ResultSrc  out 2  result select
//   ALUSrcA    out 2  ALU A select
//   ALUSrcB    out 2  ALU B select
//   ImmSrc     out 2  immediate format
//   ALUControl out 3  ALU operation
//   illegal_o  out 1  (trap build only) sitting in TRAP
//   state_o    out 4  current state, for debug
// ---------------------------------------------------------------------------
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
`ifdef MULTICYCLE_CTRL_TRAP_EN
    output logic       illegal_o,
`endif
    output logic [3:0] state_o
);

    localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

    statetype   state_q, state_d;
    logic [2:0] waitCnt_q, waitCnt_d;
    logic       waitLast;

    logic       pcUpdate, branch, irWriteRaw, memWriteRaw, regWriteRaw;
    logic [1:0] aluOp;

    assign waitLast = (waitCnt_q == WAIT_LAST);

    // Next-state logic. The wait counter only advances while a memory state
    // is being held; any transition leaves it at zero for the next state.
    always_comb begin
        state_d   = state_q;
        waitCnt_d = 3'd0;
        case (state_q)
            FETCH: begin
                if (waitLast) state_d = DECODE;
                else          waitCnt_d = waitCnt_q + 3'd1;
            end
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
`ifdef MULTICYCLE_CTRL_TRAP_EN
                    OP_R:    state_d = funct3Supported(funct3) ? EXECUTER : TRAP;
                    OP_I:    state_d = funct3Supported(funct3) ? EXECUTEI : TRAP;
`else
                    OP_R:    state_d = EXECUTER;
                    OP_I:    state_d = EXECUTEI;
`endif
                    OP_BEQ:  state_d = BEQ;
                    OP_JAL:  state_d = JAL;
`ifdef MULTICYCLE_CTRL_TRAP_EN
                    default: state_d = TRAP;
`else
                    default: state_d = FETCH;
`endif
                endcase
            end
            MEMADR:   state_d = (op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD: begin
                if (waitLast) state_d = MEMWB;
                else          waitCnt_d = waitCnt_q + 3'd1;
            end
            MEMWRITE: begin
                if (waitLast) state_d = FETCH;
                else          waitCnt_d = waitCnt_q + 3'd1;
            end
            EXECUTER, EXECUTEI, JAL: state_d = ALUWB;
            MEMWB, ALUWB, BEQ:       state_d = FETCH;
            TRAP:     state_d = TRAP;
            default:  state_d = FETCH;
        endcase
    end

    // State and wait counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= FETCH;
            waitCnt_q <= 3'd0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
        end
    end

    // Moore output decode. Enables in wait states fire only on the final
    // cycle so the PC, IR and memory each update exactly once per state.
    always_comb begin
        pcUpdate    = 1'b0;
        branch      = 1'b0;
        irWriteRaw  = 1'b0;
        memWriteRaw = 1'b0;
        regWriteRaw = 1'b0;
        AdrSrc      = 1'b0;
        ResultSrc   = RES_ALUOUT;
        ALUSrcA     = SRCA_PC;
        ALUSrcB     = SRCB_RS2;
        aluOp       = ALUOP_ADD;
        case (state_q)
            FETCH: begin
                irWriteRaw = waitLast;
                pcUpdate   = waitLast;
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALURESULT;
            end
            DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
            end
            MEMREAD: AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc   = RES_DATA;
                regWriteRaw = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc      = 1'b1;
                memWriteRaw = waitLast;
            end
            EXECUTER: begin
                ALUSrcA = SRCA_RS1;
                aluOp   = ALUOP_FUNCT;
            end
            EXECUTEI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                aluOp   = ALUOP_FUNCT;
            end
            ALUWB: regWriteRaw = 1'b1;
            BEQ: begin
                ALUSrcA = SRCA_RS1;
                aluOp   = ALUOP_SUB;
                branch  = 1'b1;
            end
            JAL: begin
                ALUSrcA  = SRCA_OLDPC;
                ALUSrcB  = SRCB_FOUR;
                pcUpdate = 1'b1;
            end
            default: ;
        endcase
    end

    // Immediate format follows the opcode directly.
    always_comb begin
        ImmSrc = IMM_I;
        case (op)
            OP_SW:   ImmSrc = IMM_S;
            OP_BEQ:  ImmSrc = IMM_B;
            OP_JAL:  ImmSrc = IMM_J;
            default: ImmSrc = IMM_I;
        endcase
    end

    // Strobes are gated by reset so nothing is written while it is held.
    assign PCWrite  = reset & (pcUpdate | (branch & Zero));
    assign IRWrite  = reset & irWriteRaw;
    assign MemWrite = reset & memWriteRaw;
    assign RegWrite = reset & regWriteRaw;
    assign state_o  = state_q;

`ifdef MULTICYCLE_CTRL_TRAP_EN
    assign illegal_o = (state_q == TRAP);
`endif

    alu_decoder u_alu_decoder (
        .ALUOp      (aluOp),
        .op5        (op[5]),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .ALUControl (ALUControl)
    );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Directed bench for multicycle_ctrl. dut0 runs with MEM_WAIT = 0 and walks
// every instruction class; dut2 runs with MEM_WAIT = 2 to exercise the wait
// states. Each cycle the state and strobe/select outputs are packed into one
// vector and compared against hand-written expectations.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

    // State codes of the design's enum.
    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2,
                           S_MEMREAD = 4'd3, S_MEMWB = 4'd4, S_MEMWRITE = 4'd5,
                           S_EXECR = 4'd6, S_EXECI = 4'd7, S_ALUWB = 4'd8,
                           S_BEQ = 4'd9, S_JAL = 4'd10, S_TRAP = 4'd11;

    // {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB}
    localparam logic [10:0] C_FETCH      = 11'b1_0_0_1_0_10_00_10;
    localparam logic [10:0] C_FETCH_OFF  = 11'b0_0_0_0_0_10_00_10;
    localparam logic [10:0] C_DECODE     = 11'b0_0_0_0_0_00_01_01;
    localparam logic [10:0] C_MEMADR     = 11'b0_0_0_0_0_00_10_01;
    localparam logic [10:0] C_MEMREAD    = 11'b0_1_0_0_0_00_00_00;
    localparam logic [10:0] C_MEMWB      = 11'b0_0_0_0_1_01_00_00;
    localparam logic [10:0] C_MEMWRITE   = 11'b0_1_1_0_0_00_00_00;
    localparam logic [10:0] C_MEMWR_WAIT = 11'b0_1_0_0_0_00_00_00;
    localparam logic [10:0] C_EXECR      = 11'b0_0_0_0_0_00_10_00;
    localparam logic [10:0] C_EXECI      = 11'b0_0_0_0_0_00_10_01;
    localparam logic [10:0] C_ALUWB      = 11'b0_0_0_0_1_00_00_00;
    localparam logic [10:0] C_BEQ_TAKEN  = 11'b1_0_0_0_0_00_10_00;
    localparam logic [10:0] C_BEQ_NOT    = 11'b0_0_0_0_0_00_10_00;
    localparam logic [10:0] C_JAL        = 11'b1_0_0_0_0_00_01_10;
    localparam logic [10:0] C_TRAP       = 11'b0_0_0_0_0_00_00_00;

    logic       clk = 1'b0;
    logic       reset, reset2;
    logic [6:0] op, op2;
    logic [2:0] funct3;
    logic       funct7b5, Zero;

    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] state_o;

    logic       PCWrite2, AdrSrc2, MemWrite2, IRWrite2, RegWrite2;
    logic [1:0] ResultSrc2, ALUSrcA2, ALUSrcB2, ImmSrc2;
    logic [2:0] ALUControl2;
    logic [3:0] state2;

`ifdef MULTICYCLE_CTRL_TRAP_EN
    logic       illegal, illegal2;
`endif

    logic [14:0] obs0, obs2, expv;
    int errors = 0;
    int checks = 0;

    assign obs0 = {state_o, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
                   ResultSrc, ALUSrcA, ALUSrcB};
    assign obs2 = {state2, PCWrite2, AdrSrc2, MemWrite2, IRWrite2, RegWrite2,
                   ResultSrc2, ALUSrcA2, ALUSrcB2};

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_WAIT(0)) dut0 (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3),
        .funct7b5(funct7b5), .Zero(Zero),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl),
`ifdef MULTICYCLE_CTRL_TRAP_EN
        .illegal_o(illegal),
`endif
        .state_o(state_o)
    );

    multicycle_ctrl #(.MEM_WAIT(2)) dut2 (
        .clk(clk), .reset(reset2), .op(op2), .funct3(funct3),
        .funct7b5(funct7b5), .Zero(Zero),
        .PCWrite(PCWrite2), .AdrSrc(AdrSrc2), .MemWrite(MemWrite2),
        .IRWrite(IRWrite2), .RegWrite(RegWrite2), .ResultSrc(ResultSrc2),
        .ALUSrcA(ALUSrcA2), .ALUSrcB(ALUSrcB2), .ImmSrc(ImmSrc2),
        .ALUControl(ALUControl2),
`ifdef MULTICYCLE_CTRL_TRAP_EN
        .illegal_o(illegal2),
`endif
        .state_o(state2)
    );

    // Advance one clock and sample away from the edge.
    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        #1;
        expv = {S_FETCH, C_FETCH_OFF}; checks++;
        if (obs0 !== expv) begin errors++; $display("[TB] FAIL reset_hold: got %h expected %h", obs0, expv); end
        cycle();
        checks++;
        if (obs0 !== expv) begin errors++; $display("[TB] FAIL reset_hold_clk: got %h expected %h", obs0, expv); end
        reset = 1'b1;
        #1;
        expv = {S_FETCH, C_FETCH}; checks++;
        if (obs0 !== expv) begin errors++; $display("[TB] FAIL reset_release: got %h expected %h", obs0, expv); end
    endtask

    task automatic test_lw();
        op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; Zero = 1'b0;
        #1;
        checks++;
        if (ImmSrc !== 2'b00) begin errors++; $display("[TB] FAIL lw_imm: got %b expected 00", ImmSrc); end
        cycle(); expv = {S_DECODE, C_DECODE}; checks++;
        if (obs0 !== expv) begin errors++; $display("[TB] FAIL lw_c2: got %h expected %h", obs0, expv); end
        cycle(); expv = {S_MEMADR, C_MEMADR}; checks++;
        if (obs0 !== expv) begin errors++; $display("[TB] FAIL lw_c3: got %h expected %h", obs0, expv); end
        checks++;
        if (ALUControl !== 3'b000) begin errors++; $display("[TB] FAIL lw_alu: got %b expected 000", ALUControl); end
        cycle(); expv = {S_MEMREAD, C_MEMREAD}; checks++;
        if (obs0 !== expv) begin errors++; $display("[TB] FAIL lw_c4: got %h expected %h", obs0, expv); end
        cycle(); expv = {S_MEMWB, C_MEMWB}; checks++;
        if (obs0 !== expv) begin errors++; $display("[TB] FAIL lw_c5: got %h expected %h", obs0, expv); end
        cycle(); expv = {S_FETCH, C_FETCH}; checks++;
        if (obs0 !== expv) begin errors++; $display("[TB] FAIL lw_done: got %h expected %h", obs0, expv); end
    endtask

    task automatic test_sw();
        op = 7'b0100011;
        #1;
        checks++;
        if (ImmSrc !== 2'b01) begin errors++; $display("[TB] FAIL sw_imm: got %b expected 01", ImmSrc); end
        cycle(); cycle();
        expv = {S_MEMADR, C_MEMADR}; checks++;
        if (obs0 !== expv) begin errors++; $display("[TB] FAIL sw_c3: got %h expected %h", obs0, expv); end
        cycle(); expv = {S_MEMWRITE, C_MEMWRITE}; checks++;
        if (obs0 !== expv) begin errors++; $display("[TB] FAIL sw_c4: got %h expected %h", obs0, expv); end
        cycle(); expv = {S_FETCH, C_FETCH}; checks++;
        if (obs0 !== expv) begin errors++; $display("[TB] FAIL sw_done: got %h expected %h", obs0, expv); end
    endtask

    task automatic test_alu_op(input logic [6:0] opc, input logic [2:0] f3,
                               input logic f7, input logic [3:0] exeState,
                               input logic [10:0] exeCtl, input logic [2:0] expAlu);
        op = opc; funct3 = f3; funct7b5 = f7;
        cycle(); cycle();
        expv = {exeState, exeCtl}; checks++;
        if (obs0 !== expv) begin errors++; $display("[TB] FAIL exe_state op=%b f3=%b: got %h expected %h", opc, f3, obs0, expv); end
        checks++;
        if (ALUControl !== expAlu) begin errors++; $display("[TB] FAIL exe_alu op=%b f3=%b f7=%b: got %b expected %b", opc, f3, f7, ALUControl, expAlu); end
        cycle(); expv = {S_ALUWB, C_ALUWB}; checks++;
        if (obs0 !== expv) begin errors++; $display("[TB] FAIL exe_wb op=%b: got %h expected %h", opc, obs0, expv); end
        cycle(); expv = {S_FETCH, C_FETCH}; checks++;
        if (obs0 !== expv) begin errors++; $display("[TB] FAIL exe_done op=%b: got %h expected %h", opc, obs0, expv); end
    endtask

    task automatic test_beq(input logic z);
        op = 7'b1100011; funct3 = 3'b000; Zero = z;
        #1;
        checks++;
        if (ImmSrc !== 2'b10) begin errors++; $display("[TB] FAIL beq_imm: got %b expected 10", ImmSrc); end
        cycle(); cycle();
        expv = {S_BEQ, (z ? C_BEQ_TAKEN : C_BEQ_NOT)}; checks++;
        if (obs0 !== expv) begin errors++; $display("[TB] FAIL beq_z%0d: got %h expected %h", z, obs0, expv); end
        checks++;
        if (ALUControl !== 3'b001) begin errors++; $display("[TB] FAIL beq_alu: got %b expected 001", ALUControl); end
        cycle(); expv = {S_FETCH, C_FETCH}; checks++;
        if (obs0 !== expv) begin errors++; $display("[TB] FAIL beq_done: got %h expected %h", obs0, expv); end
        Zero = 1'b0;
    endtask

    task automatic test_jal();
        op = 7'b1101111;
        #1;
        checks++;
        if (ImmSrc !== 2'b11) begin errors++; $display("[TB] FAIL jal_imm: got %b expected 11", ImmSrc); end
        cycle(); cycle();
        expv = {S_JAL, C_JAL}; checks++;
        if (obs0 !== expv) begin errors++; $display("[TB] FAIL jal_c3: got %h expected %h", obs0, expv); end
        cycle(); expv = {S_ALUWB, C_ALUWB}; checks++;
        if (obs0 !== expv) begin errors++; $display("[TB] FAIL jal_wb: got %h expected %h", obs0, expv); end
        cycle(); expv = {S_FETCH, C_FETCH}; checks++;
        if (obs0 !== expv) begin errors++; $display("[TB] FAIL jal_done: got %h expected %h", obs0, expv); end
    endtask

    task automatic test_reset_mid_write();
        op = 7'b0100011;
        cycle(); cycle(); cycle();
        expv = {S_MEMWRITE, C_MEMWRITE}; checks++;
        if (obs0 !== expv) begin errors++; $display("[TB] FAIL abort_pre: got %h expected %h", obs0, expv); end
        reset = 1'b0;
        #1;
        expv = {S_FETCH, C_FETCH_OFF}; checks++;
        if (obs0 !== expv) begin errors++; $display("[TB] FAIL abort_now: got %h expected %h", obs0, expv); end
        cycle(); checks++;
        if (obs0 !== expv) begin errors++; $display("[TB] FAIL abort_held: got %h expected %h", obs0, expv); end
        reset = 1'b1;
        #1;
        expv = {S_FETCH, C_FETCH}; checks++;
        if (obs0 !== expv) begin errors++; $display("[TB] FAIL abort_release: got %h expected %h", obs0, expv); end
        cycle(); expv = {S_DECODE, C_DECODE}; checks++;
        if (obs0 !== expv) begin errors++; $display("[TB] FAIL abort_resume: got %h expected %h", obs0, expv); end
        cycle(); cycle(); cycle();
    endtask

    task automatic test_unknown_op();
        op = 7'b1111111;
        cycle(); cycle();
`ifdef MULTICYCLE_CTRL_TRAP_EN
        for (int i = 0; i < 4; i++) begin
            expv = {S_TRAP, C_TRAP}; checks++;
            if (obs0 !== expv) begin errors++; $display("[TB] FAIL trap_hold%0d: got %h expected %h", i, obs0, expv); end
            checks++;
            if (illegal !== 1'b1) begin errors++; $display("[TB] FAIL trap_illegal%0d: got %b expected 1", i, illegal); end
            cycle();
        end
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        #1;
        checks++;
        if (illegal !== 1'b0) begin errors++; $display("[TB] FAIL trap_clear: got %b expected 0", illegal); end
        expv = {S_FETCH, C_FETCH}; checks++;
        if (obs0 !== expv) begin errors++; $display("[TB] FAIL trap_fetch: got %h expected %h", obs0, expv); end
`else
        expv = {S_FETCH, C_FETCH}; checks++;
        if (obs0 !== expv) begin errors++; $display("[TB] FAIL nop_skip: got %h expected %h", obs0, expv); end
`endif
    endtask

    task automatic test_mem_wait();
        op2 = 7'b0100011;
        reset2 = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            expv = {S_FETCH, (i == 2) ? C_FETCH : C_FETCH_OFF}; checks++;
            if (obs2 !== expv) begin errors++; $display("[TB] FAIL wait_fetch%0d: got %h expected %h", i, obs2, expv); end
            cycle();
        end
        expv = {S_DECODE, C_DECODE}; checks++;
        if (obs2 !== expv) begin errors++; $display("[TB] FAIL wait_decode: got %h expected %h", obs2, expv); end
        cycle(); cycle();
        for (int i = 0; i < 3; i++) begin
            expv = {S_MEMWRITE, (i == 2) ? C_MEMWRITE : C_MEMWR_WAIT}; checks++;
            if (obs2 !== expv) begin errors++; $display("[TB] FAIL wait_memwr%0d: got %h expected %h", i, obs2, expv); end
            cycle();
        end
        expv = {S_FETCH, C_FETCH_OFF}; checks++;
        if (obs2 !== expv) begin errors++; $display("[TB] FAIL wait_back: got %h expected %h", obs2, expv); end
    endtask

    initial begin
        reset = 1'b0; reset2 = 1'b0;
        op = 7'b0000000; op2 = 7'b0000000;
        funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b0;
        test_reset();
        test_lw();
        test_sw();
        test_alu_op(7'b0110011, 3'b000, 1'b1, S_EXECR, C_EXECR, 3'b001);
        test_alu_op(7'b0110011, 3'b110, 1'b0, S_EXECR, C_EXECR, 3'b011);
        test_alu_op(7'b0110011, 3'b010, 1'b0, S_EXECR, C_EXECR, 3'b101);
        test_alu_op(7'b0110011, 3'b111, 1'b0, S_EXECR, C_EXECR, 3'b010);
        test_alu_op(7'b0010011, 3'b000, 1'b1, S_EXECI, C_EXECI, 3'b000);
        test_beq(1'b1);
        test_beq(1'b0);
        test_jal();
        test_reset_mid_write();
        test_unknown_op();
        test_mem_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM for the multicycle RV32I-subset core: lw, sw, R-type, I-type ALU, beq, jal.
- Sequences the shared datapath: a single unified memory, a single ALU and PC/IR/OldPC registers.
- Sits beside the datapath in top and drives all of its select, enable and strobe lines.
- Decodes op, funct3, funct7b5 and Zero each cycle.

Parameters:
- MEM_WAIT, 0: extra wait cycles inserted in every memory-access state (FETCH, MEMREAD, MEMWRITE). Range 0..7.

Ports:
- clk  in  1  core clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset
- op  in  7  instruction opcode, Instr[6:0]
- funct3  in  3  Instr[14:12]
- funct7b5  in  1  Instr[30]
- Zero  in  1  ALU zero flag
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  IR/OldPC enable
- RegWrite  out  1  register-file write enable
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1
- ALUSrcB  out  2  ALU B select: 00 = rs2, 01 = Imm, 10 = 4
- ImmSrc  out  2  immediate format select
- ALUControl  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt
- state_o  out  4  current state, for debug

Behaviour:
- Reset
  - While reset = 0, state = FETCH and the wait counter = 0, asynchronously.
  - State outputs are Moore, so reset state outputs are FETCH outputs with strobes gated off.
  - While reset is asserted, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0.
- Per-state outputs (signals not listed default to 0):
  - FETCH: AdrSrc = 0, IRWrite = 1, ALUSrcA = 00, ALUSrcB = 10, ALUOp = 00, ResultSrc = 10, PCUpdate = 1.
  - DECODE: ALUSrcA = 01, ALUSrcB = 01, ALUOp = 00.
  - MEMADR: ALUSrcA = 10, ALUSrcB = 01, ALUOp = 00.
  - MEMREAD: ResultSrc = 00, AdrSrc = 1.
  - MEMWB: ResultSrc = 01, RegWrite = 1.
  - MEMWRITE: ResultSrc = 00, AdrSrc = 1, MemWrite = 1.
  - EXECUTER: ALUSrcA = 10, ALUSrcB = 00, ALUOp = 10.
  - EXECUTEI: ALUSrcA = 10, ALUSrcB = 01, ALUOp = 10.
  - ALUWB: ResultSrc = 00, RegWrite = 1.
  - BEQ: ALUSrcA = 10, ALUSrcB = 00, ALUOp = 01, ResultSrc = 00, Branch = 1.
  - JAL: ALUSrcA = 01, ALUSrcB = 10, ALUOp = 00, ResultSrc = 00, PCUpdate = 1.
- PC enable: PCWrite = PCUpdate | (Branch & Zero).
- Transitions
  - FETCH -> DECODE.
  - DECODE: lw or sw -> MEMADR; R-type -> EXECUTER; I-type -> EXECUTEI; beq -> BEQ; jal -> JAL.
  - MEMADR: lw -> MEMREAD; sw -> MEMWRITE.
  - MEMREAD -> MEMWB.
  - EXECUTER and EXECUTEI -> ALUWB.
  - JAL -> ALUWB.
  - MEMWB, MEMWRITE, ALUWB and BEQ -> FETCH.
- Opcodes: lw 0000011, sw 0100011, R 0110011, I 0010011, beq 1100011, jal 1101111.
- Unknown opcode in DECODE -> FETCH. The instruction is skipped as a NOP; see the optional feature.
- ImmSrc is combinational from op: lw/I 00, sw 01, beq 10, jal 11, others 00.
- ALU decoder
  - ALUOp 00 -> add; ALUOp 01 -> sub.
  - ALUOp 10 decodes funct3:
    - 000: sub when {op[5], funct7b5} = 11, else add.
    - 010: slt. 110: or. 111: and.
    - Any other funct3: 000 (add).
- Wait states (MEM_WAIT = N)
  - FETCH, MEMREAD and MEMWRITE each last N+1 cycles, counted by a 3-bit counter.
  - IRWrite, PCWrite and MemWrite assert only in the final cycle of the state.
  - Select lines are stable for the whole state.
  - The counter clears on every state exit.
- Latency with N = 0: lw 5 cycles; sw, R, I and jal 4 cycles; beq 3 cycles.
- Reset asserted mid-instruction aborts it: no further strobes, resume at FETCH.
- Outputs are combinational from the state register only, plus Zero for PCWrite.

Optional Feature:
- Macro: MULTICYCLE_CTRL_TRAP_EN.
- Defined:
  - Adds state TRAP and output illegal_o (1 bit).
  - Unknown opcode, or an unsupported R/I funct3, in DECODE -> TRAP.
  - In TRAP: all strobes are 0 and illegal_o = 1; the FSM stays there until reset.
- Not defined:
  - Port illegal_o is absent; unknown instructions follow the NOP behaviour above.

Decomposition:
- Shared package multicycle_pkg holds:
  - typedef enum logic [3:0] statetype;
  - opcode localparams;
  - ALUControl encodings;
  - ResultSrc, ALUSrcA and ALUSrcB select constants.
- One sub-module: alu_decoder, combinational, inputs ALUOp/op5/funct3/funct7b5, output ALUControl.
- The FSM stays in multicycle_ctrl.

Test Plan:
- lw (op 0000011), MEM_WAIT = 0 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB.
  - RegWrite = 1 and ResultSrc = 01 only in cycle 5; ImmSrc = 00.
- sw (op 0100011) -> MemWrite = 1 in exactly one cycle (cycle 4) with AdrSrc = 1, then FETCH.
  - With MEM_WAIT = 2: FETCH lasts 3 cycles, IRWrite only in the 3rd; MEMWRITE lasts 3 cycles, MemWrite only in the 3rd.
- R-type:
  - funct3 = 000, funct7b5 = 1 -> ALUControl = 001 in EXECUTER.
  - funct3 = 110 -> ALUControl = 011.
  - funct3 = 010 -> ALUControl = 101.
- beq:
  - Zero = 1 -> PCWrite = 1 in BEQ, ALUControl = 001.
  - Zero = 0 -> PCWrite = 0; next state FETCH.
- jal -> PCWrite = 1 in JAL and RegWrite = 1 in ALUWB; ImmSrc = 11.
- reset driven to 0 during MEMWRITE -> MemWrite falls immediately and state_o = FETCH.
  - After release: IRWrite = 1 in the first FETCH cycle.
  - With MULTICYCLE_CTRL_TRAP_EN, op 1111111 -> illegal_o = 1 held with all strobes at 0 until reset.
